accel_responder: RTL and testbench

Accelerator-side responder for custom accelerator instructions flagged at decode. Sits after the EX pipeline register, accepts one command at a time over a valid/ready request channel and runs it. Multiply is an iterative 32-cycle shift-add operation. Results return over a valid/ready response channel carrying the destination register, for writeback arbitration. Drives `busy` so the hazard logic stalls the front end while a command is outstanding.

---
 rtl/accel_responder_if.sv | 39 +++
 rtl/accel_responder.sv | 190 +++++++++++++++++++
 tb/tb_accel_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_responder_if.sv
// Request/response channel between the EX stage and the accelerator responder.
// The master side is the pipeline (issues commands, consumes results); the
// slave side is the responder itself.
interface accel_responder_if #(
  parameter int XLEN = 32
);

  // Request channel: one command, already decoded and operand-forwarded.
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1_data;
  logic [XLEN-1:0] req_rs2_data;
  logic [4:0]      req_rd;

  // Pipeline control: abort on redirect, stall request back to hazard logic.
  logic            flush;
  logic            busy;

  // Response channel toward writeback arbitration.
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic            resp_err;

  modport master (
    output req_valid, req_funct3, req_rs1_data, req_rs2_data, req_rd,
    output flush, resp_ready,
    input  req_ready, busy, resp_valid, resp_data, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1_data, req_rs2_data, req_rd,
    input  flush, resp_ready,
    output req_ready, busy, resp_valid, resp_data, resp_rd, resp_err
  );

endinterface

// File: rtl/accel_responder.sv
// Accelerator responder: accepts one custom instruction at a time, runs an
// iterative shift-add multiply (one multiplier bit per cycle) or a
// single-cycle accumulator op, and returns the result with its destination
// register. busy holds the front end while a command is outstanding.
//
// Build option: define ACCEL_MAC_EN to implement the accumulator and the
// MAC / RDACC / CLRACC commands. Without it those encodings report resp_err.
//
// MUL_CYCLES must equal XLEN so the multiplier is fully consumed.
module accel_responder #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic               clk,
  input logic               rst,
  accel_responder_if.slave  bus
);

  localparam logic [2:0] F_MUL    = 3'b000;
`ifdef ACCEL_MAC_EN
  localparam logic [2:0] F_MAC    = 3'b001;
  localparam logic [2:0] F_RDACC  = 3'b010;
  localparam logic [2:0] F_CLRACC = 3'b011;
`endif

  // One extra bit keeps the width legal for any MUL_CYCLES >= 1.
  localparam int              CW       = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_RESP
  } state_t;

  state_t          state, state_next;

  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic [XLEN-1:0] product;
  logic [XLEN-1:0] product_next;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] resp_data_q;
  logic [4:0]      resp_rd_q;
  logic            resp_err_q;

  logic            accept;
  logic            start_mul;
  logic            mul_step;
  logic            mul_last;
  logic [XLEN-1:0] single_data;
  logic            single_err;
  logic [XLEN-1:0] mul_result;

`ifdef ACCEL_MAC_EN
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_sum;
  logic            is_mac;
`endif

  // Commands that go through the iterative multiplier.
`ifdef ACCEL_MAC_EN
  assign start_mul = (bus.req_funct3 == F_MUL) || (bus.req_funct3 == F_MAC);
`else
  assign start_mul = (bus.req_funct3 == F_MUL);
`endif

  // One shift-add iteration; wraps modulo 2^XLEN.
  assign product_next = multiplier[0] ? (product + multiplicand) : product;

`ifdef ACCEL_MAC_EN
  assign acc_sum    = acc + product_next;
  assign mul_result = is_mac ? acc_sum : product_next;
`else
  assign mul_result = product_next;
`endif

  // Result of the single-cycle commands, evaluated on the accept edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    single_data = '0;
    single_err  = 1'b1;
`ifdef ACCEL_MAC_EN
    case (bus.req_funct3)
      F_RDACC: begin
        single_data = acc;
        single_err  = 1'b0;
      end
      F_CLRACC: single_err = 1'b0;
      default: ;
    endcase
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and control decode; flush outranks every other event.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_step   = 1'b0;
    mul_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          accept     = 1'b1;
          state_next = start_mul ? S_MUL : S_RESP;
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          state_next = S_IDLE;
        end else begin
          mul_step = 1'b1;
          if (count == LAST_CNT) begin
            mul_last   = 1'b1;
            state_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.flush || bus.resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, shift-add datapath and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multiplicand <= '0;
      multiplier   <= '0;
      product      <= '0;
      count        <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      multiplicand <= bus.req_rs1_data;
      multiplier   <= bus.req_rs2_data;
      product      <= '0;
      count        <= '0;
      resp_rd_q    <= bus.req_rd;
      if (!start_mul) begin
        resp_data_q <= single_data;
        resp_err_q  <= single_err;
      end
    end else if (mul_step) begin
      product      <= product_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      count        <= count + 1'b1;
      if (mul_last) begin
        resp_data_q <= mul_result;
        resp_err_q  <= 1'b0;
      end
    end
  end

`ifdef ACCEL_MAC_EN
  // Accumulator: cleared by CLRACC, updated only when a MAC completes, so a
  // flushed MAC leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      is_mac <= 1'b0;
    end else begin
      if (accept) is_mac <= (bus.req_funct3 == F_MAC);
      if (accept && bus.req_funct3 == F_CLRACC) acc <= '0;
      else if (mul_last && is_mac)              acc <= acc_sum;
    end
  end
`endif

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state != S_IDLE) || bus.req_valid;

endmodule

// File: tb/tb_accel_responder.sv
// Directed bench for accel_responder with a scoreboard queue: expectations
// are pushed when a command is issued and popped when its response appears.
module tb_accel_responder;

  logic clk = 1'b0;
  logic rst;

  accel_responder_if #(.XLEN(32)) bus ();

  accel_responder #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_acc = '0;

`ifdef ACCEL_MAC_EN
  localparam logic [2:0] FLUSH_OP = 3'b001;
`else
  localparam logic [2:0] FLUSH_OP = 3'b000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one accepted command; lat counts edges from the
  // accept edge to the first edge that samples resp_valid high.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output exp_t e);
    e.rd  = rd;
    e.err = 1'b0;
    e.lat = 1;
    e.data = '0;
    case (f3)
      3'b000: begin e.data = a * b; e.lat = 33; end
`ifdef ACCEL_MAC_EN
      3'b001: begin model_acc = model_acc + a * b; e.data = model_acc; e.lat = 33; end
      3'b010: e.data = model_acc;
      3'b011: model_acc = '0;
`endif
      default: e.err = 1'b1;
    endcase
  endtask

  // Issue one command; it must be accepted on the next rising edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit push);
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_funct3   = f3;
    bus.req_rs1_data = a;
    bus.req_rs2_data = b;
    bus.req_rd       = rd;
    check("req_ready_before_accept", bus.req_ready, 1);
    if (push) begin
      model(f3, a, b, rd, e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for a response, compare it with the scoreboard head, optionally
  // stall resp_ready for hold cycles, then confirm the return to idle.
  task automatic receive(input int hold);
    int          lat = 1;
    bit          busy_ok = 1'b1;
    bit          stable_ok = 1'b1;
    exp_t        e;
    logic [31:0] d0;
    logic [4:0]  r0;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_valid_seen", bus.resp_valid, 1);
    check("busy_while_outstanding", busy_ok, 1);
    check("scoreboard_nonempty", exp_q.size() > 0, 1);
    e = '{32'd0, 5'd0, 1'b0, 0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("resp_data", bus.resp_data, e.data);
    check("resp_rd", bus.resp_rd, e.rd);
    check("resp_err", bus.resp_err, e.err);
    check("latency", lat, e.lat);
    d0 = bus.resp_data;
    r0 = bus.resp_rd;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b101;
      @(posedge clk);
      #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== d0 ||
          bus.resp_rd !== r0 || bus.req_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) begin
      check("held_response_stable", stable_ok, 1);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after_handshake_valid", bus.resp_valid, 0);
    check("idle_after_handshake_ready", bus.req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_funct3   = '0;
    bus.req_rs1_data = '0;
    bus.req_rs2_data = '0;
    bus.req_rd       = '0;
    bus.flush        = 1'b0;
    bus.resp_ready   = 1'b1;

    // Reset values, and busy following req_valid combinationally.
    #12;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_rd", bus.resp_rd, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_busy", bus.busy, 0);
    bus.req_valid = 1'b1;
    #1;
    check("busy_follows_req_valid", bus.busy, 1);
    bus.req_valid = 1'b0;
    #1;
    check("busy_drops_with_req_valid", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic multiply and wrap-around.
    send(3'b000, 32'd7, 32'd6, 5'd5, 1); receive(0);
    send(3'b000, 32'hFFFF_FFFF, 32'd2, 5'd9, 1); receive(0);

    // Accumulate twice, then read the accumulator.
    send(3'b001, 32'd3, 32'd4, 5'd10, 1); receive(0);
    send(3'b001, 32'd3, 32'd4, 5'd11, 1); receive(0);
    send(3'b010, 32'd0, 32'd0, 5'd12, 1); receive(0);

    // Writeback stalls for 10 cycles on a multiply result.
    bus.resp_ready = 1'b0;
    send(3'b000, 32'd5, 32'd9, 5'd13, 1); receive(10);

    // Bring acc to 5, flush a MAC mid-iteration, read acc back.
    send(3'b011, 32'd0, 32'd0, 5'd1, 1); receive(0);
    send(3'b001, 32'd1, 32'd5, 5'd2, 1); receive(0);
    send(FLUSH_OP, 32'd2, 32'd3, 5'd4, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_mul_to_idle", bus.req_ready, 1);
    check("flush_mul_no_valid", bus.resp_valid, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check("no_response_after_flush", seen, 0);
    send(3'b010, 32'd0, 32'd0, 5'd6, 1); receive(0);

    // Flush together with req_valid in IDLE: command is not accepted.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b101;
    bus.flush      = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle_not_accepted_valid", bus.resp_valid, 0);
    check("flush_idle_not_accepted_ready", bus.req_ready, 1);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;

    // Flush and resp_ready in the same RESP cycle: response dropped.
    bus.resp_ready = 1'b0;
    send(3'b101, 32'd0, 32'd0, 5'd8, 0);
    check("resp_pending_before_flush", bus.resp_valid, 1);
    @(negedge clk);
    bus.flush      = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_resp_dropped", bus.resp_valid, 0);
    check("flush_resp_idle", bus.req_ready, 1);
    @(negedge clk);
    bus.flush = 1'b0;

    // Reset in the middle of a multiply.
    send(3'b000, 32'd9, 32'd9, 5'd7, 0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_resp_data", bus.resp_data, 0);
    check("midrst_resp_rd", bus.resp_rd, 0);
    check("midrst_resp_err", bus.resp_err, 0);
    check("midrst_busy", bus.busy, 0);
    model_acc = '0;
    @(negedge clk);
    rst = 1'b0;
    send(3'b000, 32'd2, 32'd3, 5'd14, 1); receive(0);
    send(3'b010, 32'd0, 32'd0, 5'd15, 1); receive(0);

    // Unsupported encoding, then clear and read the accumulator.
    send(3'b101, 32'd1, 32'd1, 5'd16, 1); receive(0);
    send(3'b001, 32'd3, 32'd3, 5'd17, 1); receive(0);
    send(3'b011, 32'd0, 32'd0, 5'd18, 1); receive(0);
    send(3'b010, 32'd0, 32'd0, 5'd19, 1); receive(0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
